// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit constants, countdown state type and digit validity check.
// Used by the countdown top (bcd_countdown) and the single-digit decrement cell.
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_NINE    = 4'd9;
    localparam logic [3:0] BCD_ZERO    = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] digit);
        return digit <= BCD_NINE;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Combinational single-digit BCD decrement with borrow chain in/out.
module bcd_digit_dec
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    input  logic                   borrow_in,
    output logic [BCD_DIGIT_W-1:0] digit_out,
    output logic                   borrow_out
);

    always_comb begin
        digit_out  = digit;
        borrow_out = borrow_in && (digit == BCD_ZERO);
        if (borrow_in) begin
            digit_out = (digit == BCD_ZERO) ? BCD_NINE : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// N-digit BCD down-counter with load validation, IDLE/RUN/DONE control and done pulse.
// Define BCD_COUNTDOWN_WRAP_EN to reload from the last loaded value at terminal count.
module bcd_countdown
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                start,
    input  logic                stop,
    input  logic                tick,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                zero,
    output logic                done,
    output logic                load_err
);

    localparam int         W       = 4 * DIGITS;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    state_t         r_state;
    logic [W-1:0]   r_count;
    logic [W-1:0]   r_reload;
    logic           r_zero;
    logic           r_done;
    logic           r_load_err;

    state_t         w_state_nxt;
    logic [W-1:0]   w_count_nxt;
    logic [W-1:0]   w_reload_nxt;
    logic           w_done_nxt;
    logic           w_err_nxt;
    logic           w_load_ok;
    logic           w_tick_en;
    logic [W-1:0]   w_dec;
    logic [DIGITS:0] w_borrow;

    // A tick only acts when no higher-priority command is present this cycle.
    assign w_tick_en   = tick && !load && !stop && !start && (r_state == RUN);
    assign w_borrow[0] = w_tick_en;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_dec u_dig (
            .digit      (r_count[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .borrow_in  (w_borrow[g]),
            .digit_out  (w_dec[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .borrow_out (w_borrow[g+1])
        );
    end

    always_comb begin
        w_load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(load_value[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                w_load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        if (load) begin
            if (w_load_ok) begin
                w_count_nxt  = load_value;
                w_reload_nxt = load_value;
                w_state_nxt  = IDLE;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (stop) begin
            if (r_state == RUN) w_state_nxt = IDLE;
        end else if (start) begin
            if (r_state == IDLE && r_count != '0) w_state_nxt = RUN;
        end else if (w_tick_en) begin
            if (r_count == CNT_ONE) begin
                w_done_nxt = 1'b1;
`ifdef BCD_COUNTDOWN_WRAP_EN
                if (r_reload != '0) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = DONE;
                end
`else
                w_count_nxt = '0;
                w_state_nxt = DONE;
`endif
            end else if (!w_borrow[DIGITS]) begin
                // Top-digit borrow would mean underflow past zero; never let it land.
                w_count_nxt = w_dec;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_zero     <= 1'b1;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_reload   <= w_reload_nxt;
            r_zero     <= (w_count_nxt == '0);
            r_done     <= w_done_nxt;
            r_load_err <= w_err_nxt;
        end
    end

    assign count    = r_count;
    assign running  = (r_state == RUN);
    assign zero     = r_zero;
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: directed vector table, terminal/reset sequences, random run vs value model.
module tb_bcd_countdown;

    localparam int DIGITS = 3;

    logic        clk;
    logic        rst;
    logic        load;
    logic [11:0] load_value;
    logic        start;
    logic        stop;
    logic        tick;
    logic [11:0] count;
    logic        running;
    logic        zero;
    logic        done;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    bcd_countdown #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .count      (count),
        .running    (running),
        .zero       (zero),
        .done       (done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ld;
        logic [11:0] lv;
        logic        st;
        logic        sp;
        logic        tk;
        logic [11:0] c;
        logic        r;
        logic        z;
        logic        d;
        logic        e;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic ld, logic [11:0] lv, logic st, logic sp, logic tk,
                                logic [11:0] c, logic r, logic z, logic d, logic e);
        vec_t v;
        v.name = nm; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.tk = tk;
        v.c = c; v.r = r; v.z = z; v.d = d; v.e = e;
        vecs.push_back(v);
    endfunction

    // Reference model: count kept as a plain integer, state as 0=idle 1=run 2=done.
    int m_val, m_reload, m_state;
    bit m_done, m_err;

    function automatic logic [11:0] to_bcd(int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit bcd_ok(logic [11:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
    endfunction

    function automatic int from_bcd(logic [11:0] b);
        return int'(b[3:0]) + 10 * int'(b[7:4]) + 100 * int'(b[11:8]);
    endfunction

    task automatic model_reset();
        m_val = 0; m_reload = 0; m_state = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        m_err  = 0;
        if (load) begin
            if (bcd_ok(load_value)) begin
                m_val = from_bcd(load_value); m_reload = m_val; m_state = 0;
            end else begin
                m_err = 1;
            end
        end else if (stop) begin
            if (m_state == 1) m_state = 0;
        end else if (start) begin
            if (m_state == 0 && m_val != 0) m_state = 1;
        end else if (tick && m_state == 1) begin
            m_val = m_val - 1;
            if (m_val == 0) begin
                m_done = 1;
`ifdef BCD_COUNTDOWN_WRAP_EN
                if (m_reload != 0) m_val = m_reload;
                else m_state = 2;
`else
                m_state = 2;
`endif
            end
        end
    endtask

    task automatic check(string nm, logic [11:0] ec, logic er, logic ez, logic ed, logic ee);
        checks++;
        if ({count, running, zero, done, load_err} !== {ec, er, ez, ed, ee}) begin
            errors++;
            $display("FAIL %s: got count=%h run=%b zero=%b done=%b err=%b, expected count=%h run=%b zero=%b done=%b err=%b",
                     nm, count, running, zero, done, load_err, ec, er, ez, ed, ee);
        end
    endtask

    task automatic drive(logic ld, logic [11:0] lv, logic st, logic sp, logic tk);
        load = ld; load_value = lv; start = st; stop = sp; tick = tk;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 12'h000, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 12'h000, 0, 0, 0);

        // Directed table: each entry is one clock with its expected registered outputs.
        add("load259",   1, 12'h259, 0, 0, 0, 12'h259, 0, 0, 0, 0);
        add("start259",  0, 12'h000, 1, 0, 0, 12'h259, 1, 0, 0, 0);
        add("tick258",   0, 12'h000, 0, 0, 1, 12'h258, 1, 0, 0, 0);
        add("load100",   1, 12'h100, 0, 0, 0, 12'h100, 0, 0, 0, 0);
        add("start100",  0, 12'h000, 1, 0, 0, 12'h100, 1, 0, 0, 0);
        add("tick099",   0, 12'h000, 0, 0, 1, 12'h099, 1, 0, 0, 0);
        add("tick098",   0, 12'h000, 0, 0, 1, 12'h098, 1, 0, 0, 0);
        add("stop098",   0, 12'h000, 0, 1, 1, 12'h098, 0, 0, 0, 0);
        add("idletick",  0, 12'h000, 0, 0, 1, 12'h098, 0, 0, 0, 0);
        add("starttick", 0, 12'h000, 1, 0, 1, 12'h098, 1, 0, 0, 0);
        add("badload",   1, 12'h1A3, 1, 0, 0, 12'h098, 1, 0, 0, 1);
        add("errclear",  0, 12'h000, 0, 0, 0, 12'h098, 1, 0, 0, 0);
        add("ldstart",   1, 12'h005, 1, 0, 0, 12'h005, 0, 0, 0, 0);
        add("start005",  0, 12'h000, 1, 0, 0, 12'h005, 1, 0, 0, 0);
        add("tick004",   0, 12'h000, 0, 0, 1, 12'h004, 1, 0, 0, 0);
        add("tick003",   0, 12'h000, 0, 0, 1, 12'h003, 1, 0, 0, 0);
        add("stop003",   0, 12'h000, 0, 1, 0, 12'h003, 0, 0, 0, 0);
        add("held1",     0, 12'h000, 0, 0, 1, 12'h003, 0, 0, 0, 0);
        add("held2",     0, 12'h000, 0, 0, 1, 12'h003, 0, 0, 0, 0);
        add("held3",     0, 12'h000, 0, 0, 1, 12'h003, 0, 0, 0, 0);
        add("restart",   0, 12'h000, 1, 0, 0, 12'h003, 1, 0, 0, 0);
        add("tick002",   0, 12'h000, 0, 0, 1, 12'h002, 1, 0, 0, 0);
        add("tick001",   0, 12'h000, 0, 0, 1, 12'h001, 1, 0, 0, 0);
        add("load000",   1, 12'h000, 0, 0, 0, 12'h000, 0, 1, 0, 0);
        add("start0",    0, 12'h000, 1, 0, 0, 12'h000, 0, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset", 12'h000, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].tk);
            step();
            check(vecs[i].name, vecs[i].c, vecs[i].r, vecs[i].z, vecs[i].d, vecs[i].e);
        end

`ifdef BCD_COUNTDOWN_WRAP_EN
        drive(1, 12'h003, 0, 0, 0); step();
        drive(0, 12'h000, 1, 0, 0); step();
        check("wrapstart", 12'h003, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            logic [11:0] ec;
            ec = to_bcd(2 - (i % 3) == 0 ? 3 : 2 - (i % 3));
            drive(0, 12'h000, 0, 0, 1); step();
            check("wraptick", ec, 1, 0, (i % 3 == 2), 0);
        end
`else
        drive(1, 12'h002, 0, 0, 0); step();
        drive(0, 12'h000, 1, 0, 0); step();
        drive(0, 12'h000, 0, 0, 1); step();
        check("term1", 12'h001, 1, 0, 0, 0);
        step();
        check("term0", 12'h000, 0, 1, 1, 0);
        step();
        check("donepulse", 12'h000, 0, 1, 0, 0);
        drive(0, 12'h000, 1, 0, 1); step();
        check("donestart", 12'h000, 0, 1, 0, 0);
        drive(0, 12'h000, 0, 0, 1); step();
        check("donetick", 12'h000, 0, 1, 0, 0);
        drive(1, 12'hA00, 0, 0, 0); step();
        check("donebadld", 12'h000, 0, 1, 0, 1);
        drive(0, 12'h000, 1, 0, 0); step();
        check("donehold", 12'h000, 0, 1, 0, 0);
        drive(1, 12'h001, 0, 0, 0); step();
        drive(0, 12'h000, 1, 0, 0); step();
        drive(0, 12'h000, 0, 0, 1); step();
        check("oneshot", 12'h000, 0, 1, 1, 0);
`endif
        // Asynchronous reset between edges must clear a pending done immediately.
        #2 rst = 1'b1;
        #1 check("asyncrst", 12'h000, 0, 1, 0, 0);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            logic [11:0] lv;
            if ($urandom_range(0, 3) == 0) lv = 12'($urandom);
            else lv = to_bcd($urandom_range(0, 25));
            drive($urandom_range(0, 15) == 0, lv, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
            model_step();
            step();
            check("random", to_bcd(m_val), m_state == 1, m_val == 0, m_done, m_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- Sequential N-digit BCD down-counter; the decrementing counterpart to the team's BCD incrementer.
- Loads a BCD value, then counts down one step per tick pulse while running, and flags completion at 0.
- Drives countdown displays on the 12864 LCD demo.
- Tick comes from an external prescaler; count feeds the digit-to-glyph path directly.

Parameters:
- DIGITS, 3, number of BCD digits; count width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  load strobe; captures load_value.
- load_value  input  4*DIGITS  BCD value to load; digit 0 is in [3:0].
- start  input  1  begin or resume counting.
- stop  input  1  pause counting; count is held.
- tick  input  1  single-cycle decrement enable.
- count  output  4*DIGITS  current BCD value (registered).
- running  output  1  high in RUN state.
- zero  output  1  high when count equals all-zero digits (registered).
- done  output  1  one-cycle pulse when count reaches zero from a tick.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, rst=1): count=0, state=IDLE, running=0, zero=1, done=0, load_err=0, reload register=0.
- States: IDLE, RUN, DONE.
- Input priority per cycle: load > stop > start > tick.
- load, any state:
  - If every digit of load_value is ≤9: count and reload register take load_value at the next edge, state→IDLE.
  - Otherwise: nothing changes and load_err pulses for 1 cycle.
- start in IDLE with count≠0: RUN at the next edge.
- start in IDLE with count=0, or start in DONE: ignored.
- stop in RUN: IDLE, count held.
- tick in RUN: count decrements by one in BCD at the next edge (latency 1).
  - A digit at 0 becomes 9 and borrows from the next higher digit; a digit above 0 decrements without borrow.
- Tick reaching zero (count=...001 in RUN with tick): count becomes 0, state→DONE, done=1 for exactly that cycle.
- tick in IDLE or DONE: ignored; count never underflows past 0.
- DONE: count held at 0. Exit only via load (to IDLE) or rst.
- Same cycle as a state entry: start+tick in IDLE gives RUN with no decrement that cycle.
- zero and done are registered alongside count; no combinational paths from inputs to outputs.
- Mid-run rst clears everything immediately; a done pulse is cancelled.

Optional Feature:
- Macro: BCD_COUNTDOWN_WRAP_EN.
- Defined:
  - A tick at count=...001 in RUN loads the reload register into count, stays in RUN, and pulses done. This gives a periodic timer.
  - If the reload register is 0, the counter enters DONE instead.
  - zero is never asserted during wrap operation.
- Undefined: terminal behaviour exactly as above (stop at 0 in DONE). The reload register is still required for load.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W=4, BCD_NINE=4'd9, BCD_ZERO=4'd0.
  - State enum typedef {IDLE, RUN, DONE}.
  - Function bcd_digit_valid (digit ≤9), also usable by the incrementer bench.
- One sub-module, bcd_digit_dec: combinational single-digit decrement.
  - Inputs: digit, borrow_in.
  - Outputs: digit_out, borrow_out.
  - Instantiated DIGITS times in a generate chain. Digit 0 borrow_in=tick-qualified enable.
- FSM, reload register and load validation live in the top module.

Test Plan:
- Reset, then load 0x259, start, 1 tick → count=0x258, running=1, zero=0, done=0.
- Load 0x100, start, 1 tick → count=0x099 (double borrow); next tick → 0x098.
- Load 0x002, start, 2 ticks → count=0x000, done high exactly 1 cycle, state DONE. Further ticks and start leave count=0, running=0.
- Load 0x1A3 → load_err 1-cycle pulse; count and state unchanged. Load and start in the same cycle → load wins, state IDLE.
- Load 0x005, start, 2 ticks, stop, 3 ticks → count=0x003. Start, 3 ticks → 0x000, done.
- With BCD_COUNTDOWN_WRAP_EN: load 0x003, start, 6 ticks → count sequence 2,1,3,2,1,3 with done pulsed twice; async rst mid-run → count=0, zero=1, done=0 immediately.
